// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU external-SRAM controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } sram_state_e;

  localparam int         SRAM_DW       = 16;
  localparam logic [3:0] BYTE_MASK_ALL = 4'hF;

endpackage

// File: rtl/lsu_sram_ctrl_if.sv
// Core-side LSU data-memory bus.
//   master (core): drives req/wren/addr/wdata/bmask, receives rdata/ack/stall
//   slave  (ctrl): the reverse
interface lsu_sram_ctrl_if;
  logic        req;
  logic        wren;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  bmask;
  logic [31:0] rdata;
  logic        ack;
  logic        stall;

  modport master (output req, wren, addr, wdata, bmask,
                  input  rdata, ack, stall);
  modport slave  (input  req, wren, addr, wdata, bmask,
                  output rdata, ack, stall);
endinterface

// File: rtl/lsu_sram_ctrl_wait_ctr.sv
// Loadable down-counter; o_last is high while the count is zero.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_load       : load i_load_val this cycle
//   o_last       : count == 0
module sram_wait_ctr #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_last
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_load)              count_d = i_load_val;
    else if (count_q != '0)  count_d = count_q - W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) count_q <= '0;
    else       count_q <= count_d;
  end

  assign o_last = (count_q == '0);

endmodule

// File: rtl/lsu_sram_ctrl.sv
// Splits 32-bit LSU loads/stores into two 16-bit async-SRAM phases
// (low halfword, then high halfword), stalling the core until done.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   lsu              : core-side request/ack bus (slave)
//   o_sram_addr      : halfword address {word addr, phase}
//   io_sram_dq       : bidirectional SRAM data
//   o_sram_*_n       : active-low SRAM strobes, all registered
module lsu_sram_ctrl import lsu_pkg::*; #(
  parameter int WAIT_CYC = 1,
  parameter int SRAM_AW  = 18
) (
  input  logic               i_clk,
  input  logic               i_rst,
  lsu_sram_ctrl_if.slave     lsu,
  output logic [SRAM_AW-1:0] o_sram_addr,
  inout  wire  [SRAM_DW-1:0] io_sram_dq,
  output logic               o_sram_ce_n,
  output logic               o_sram_we_n,
  output logic               o_sram_oe_n,
  output logic               o_sram_lb_n,
  output logic               o_sram_ub_n
);

  localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  sram_state_e          state_q, state_d;
  logic                 wren_q, wren_d;
  logic [SRAM_AW-2:0]   addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           bmask_q, bmask_d;
  logic [SRAM_DW-1:0]   rdata_lo_q, rdata_lo_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 ack_q, ack_d;
  logic [SRAM_AW-1:0]   sram_addr_q, sram_addr_d;
  logic                 ce_n_q, ce_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
  logic                 lb_n_q, lb_n_d, ub_n_q, ub_n_d;
  logic                 dq_oe_q, dq_oe_d;
  logic [SRAM_DW-1:0]   dq_out_q, dq_out_d;
  logic                 ctr_load, phase_last, hi_ph;
  logic                 unused_addr;

  assign unused_addr = ^{lsu.addr[31:SRAM_AW+1], lsu.addr[1:0]};

  sram_wait_ctr #(.W(CW)) u_wait_ctr (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (ctr_load),
    .i_load_val (CW'(WAIT_CYC - 1)),
    .o_last     (phase_last)
  );

  always_comb begin
    state_d    = state_q;
    wren_d     = wren_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    bmask_d    = bmask_q;
    rdata_lo_d = rdata_lo_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      IDLE: if (lsu.req) begin
        wren_d  = lsu.wren;
        addr_d  = lsu.addr[SRAM_AW:2];
        wdata_d = lsu.wdata;
        bmask_d = lsu.wren ? lsu.bmask : BYTE_MASK_ALL;
        if (lsu.wren && lsu.bmask == 4'h0)            state_d = DONE;
        else if (lsu.wren && lsu.bmask[1:0] == 2'b00) state_d = HI;
        else                                          state_d = LO;
      end
      LO: if (phase_last) begin
        if (!wren_q) rdata_lo_d = io_sram_dq;
        state_d = (wren_q && bmask_q[3:2] == 2'b00) ? DONE : HI;
      end
      HI: if (phase_last) begin
        // o_rdata only changes once the whole word is in
        if (!wren_q) rdata_d = {io_sram_dq, rdata_lo_q};
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ctr_load = (state_d == LO || state_d == HI) && (state_d != state_q);
    ack_d    = (state_d == DONE);

    // Pins are computed from the next state so they are glitch-free flops
    // aligned with the state they belong to.
    hi_ph       = (state_d == HI);
    sram_addr_d = sram_addr_q;
    ce_n_d      = 1'b1;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    lb_n_d      = 1'b1;
    ub_n_d      = 1'b1;
    dq_oe_d     = 1'b0;
    dq_out_d    = dq_out_q;
    if (state_d == LO || state_d == HI) begin
      ce_n_d      = 1'b0;
      sram_addr_d = {addr_d, hi_ph};
      if (wren_d) begin
        we_n_d   = 1'b0;
        dq_oe_d  = 1'b1;
        dq_out_d = hi_ph ? wdata_d[31:16] : wdata_d[15:0];
        lb_n_d   = ~(hi_ph ? bmask_d[2] : bmask_d[0]);
        ub_n_d   = ~(hi_ph ? bmask_d[3] : bmask_d[1]);
      end else begin
        oe_n_d = 1'b0;
        lb_n_d = 1'b0;
        ub_n_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      wren_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      bmask_q     <= '0;
      rdata_lo_q  <= '0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      sram_addr_q <= '0;
      ce_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      wren_q      <= wren_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      bmask_q     <= bmask_d;
      rdata_lo_q  <= rdata_lo_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      sram_addr_q <= sram_addr_d;
      ce_n_q      <= ce_n_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      lb_n_q      <= lb_n_d;
      ub_n_q      <= ub_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
    end
  end

  assign lsu.rdata  = rdata_q;
  assign lsu.ack    = ack_q;
  assign lsu.stall  = (lsu.req && state_q == IDLE) || state_q == LO || state_q == HI;
  assign o_sram_addr = sram_addr_q;
  assign o_sram_ce_n = ce_n_q;
  assign o_sram_we_n = we_n_q;
  assign o_sram_oe_n = oe_n_q;
  assign o_sram_lb_n = lb_n_q;
  assign o_sram_ub_n = ub_n_q;
  assign io_sram_dq  = dq_oe_q ? dq_out_q : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_lsu_sram_ctrl.sv
module tb_lsu_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        t_sel;
  logic        t_req, t_wren;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_bmask;
  int          n_tests = 0;
  int          n_fail  = 0;

  lsu_sram_ctrl_if bus1();
  lsu_sram_ctrl_if bus3();

  assign bus1.req = t_req && !t_sel;  assign bus3.req = t_req && t_sel;
  assign bus1.wren = t_wren;          assign bus3.wren = t_wren;
  assign bus1.addr = t_addr;          assign bus3.addr = t_addr;
  assign bus1.wdata = t_wdata;        assign bus3.wdata = t_wdata;
  assign bus1.bmask = t_bmask;        assign bus3.bmask = t_bmask;

  wire  [15:0] dq1, dq3;
  logic [17:0] sa1, sa3;
  logic ce1, we1, oe1, lb1, ub1, ce3, we3, oe3, lb3, ub3;

  lsu_sram_ctrl #(.WAIT_CYC(1), .SRAM_AW(18)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .lsu(bus1), .o_sram_addr(sa1), .io_sram_dq(dq1),
    .o_sram_ce_n(ce1), .o_sram_we_n(we1), .o_sram_oe_n(oe1),
    .o_sram_lb_n(lb1), .o_sram_ub_n(ub1));

  lsu_sram_ctrl #(.WAIT_CYC(3), .SRAM_AW(18)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .lsu(bus3), .o_sram_addr(sa3), .io_sram_dq(dq3),
    .o_sram_ce_n(ce3), .o_sram_we_n(we3), .o_sram_oe_n(oe3),
    .o_sram_lb_n(lb3), .o_sram_ub_n(ub3));

  // Async SRAM models (only the low 8 address bits are populated)
  logic [15:0] mem1 [0:255];
  logic [15:0] mem3 [0:255];
  assign dq1 = (!ce1 && !oe1 && we1) ? mem1[sa1[7:0]] : 16'hzzzz;
  assign dq3 = (!ce3 && !oe3 && we3) ? mem3[sa3[7:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ce1 && !we1) begin
      if (!lb1) mem1[sa1[7:0]][7:0]  <= dq1[7:0];
      if (!ub1) mem1[sa1[7:0]][15:8] <= dq1[15:8];
    end
    if (!ce3 && !we3) begin
      if (!lb3) mem3[sa3[7:0]][7:0]  <= dq3[7:0];
      if (!ub3) mem3[sa3[7:0]][15:8] <= dq3[15:8];
    end
  end

  logic [15:0] o_dq;
  logic [17:0] o_addr;
  logic        o_ce, o_we, o_oe, o_lb, o_ub, o_stall, o_ack;
  logic [31:0] o_rdata;
  assign o_dq    = t_sel ? dq3 : dq1;
  assign o_addr  = t_sel ? sa3 : sa1;
  assign o_ce    = t_sel ? ce3 : ce1;
  assign o_we    = t_sel ? we3 : we1;
  assign o_oe    = t_sel ? oe3 : oe1;
  assign o_lb    = t_sel ? lb3 : lb1;
  assign o_ub    = t_sel ? ub3 : ub1;
  assign o_stall = t_sel ? bus3.stall : bus1.stall;
  assign o_ack   = t_sel ? bus3.ack   : bus1.ack;
  assign o_rdata = t_sel ? bus3.rdata : bus1.rdata;

  // Reference model: halfword memory image and last completed load per DUT
  logic [15:0] em [0:1][0:255];
  logic [31:0] last_rd [0:1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle_pins(input string tag);
    chk({tag, " ce_n"}, 32'(o_ce), 32'd1);
    chk({tag, " we_n"}, 32'(o_we), 32'd1);
    chk({tag, " oe_n"}, 32'(o_oe), 32'd1);
    chk({tag, " lb_n"}, 32'(o_lb), 32'd1);
    chk({tag, " ub_n"}, 32'(o_ub), 32'd1);
  endtask

  // Issues one access starting in the current cycle and checks every cycle
  // until the ack cycle. Called at posedge+1.
  task automatic run_access(input logic sel, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] bm, input logic keep_req,
                            output int ack_cycle, output logic [31:0] rd);
    int w;
    int ph[$];
    int total;
    int p;
    logic active;
    logic [16:0] base;
    logic [17:0] hw;
    logic [31:0] exp_rd;
    w = sel ? 3 : 1;
    if (!wr) begin ph.push_back(0); ph.push_back(1); end
    else begin
      if (bm[1:0] != 2'b00) ph.push_back(0);
      if (bm[3:2] != 2'b00) ph.push_back(1);
    end
    total = 1 + ph.size() * w + 1;
    base  = addr[18:2];
    hw    = {base, 1'b0};
    exp_rd[15:0]  = em[sel][hw[7:0]];
    hw    = {base, 1'b1};
    exp_rd[31:16] = em[sel][hw[7:0]];
    ack_cycle = -1;
    rd = 32'h0;
    t_sel = sel; t_wren = wr; t_addr = addr; t_wdata = wd; t_bmask = bm; t_req = 1'b1;
    for (int c = 0; c < total; c++) begin
      if (c == 1) begin
        t_wren = ~wr; t_addr = ~addr; t_wdata = ~wd; t_bmask = ~bm;
      end
      if (c == total - 1) t_req = keep_req;
      @(negedge clk);
      active = (c >= 1 && c <= total - 2);
      chk("stall", 32'(o_stall), 32'(c < total - 1));
      chk("ack", 32'(o_ack), 32'(c == total - 1));
      if (active) begin
        p  = ph[(c - 1) / w];
        hw = {base, p[0]};
        chk("ce_n", 32'(o_ce), 32'd0);
        chk("sram_addr", 32'(o_addr), 32'(hw));
        if (wr) begin
          chk("st we_n", 32'(o_we), 32'd0);
          chk("st oe_n", 32'(o_oe), 32'd1);
          chk("st lb_n", 32'(o_lb), 32'(!bm[2*p]));
          chk("st ub_n", 32'(o_ub), 32'(!bm[2*p+1]));
          chk("st dq", 32'(o_dq), 32'(p == 1 ? wd[31:16] : wd[15:0]));
        end else begin
          chk("ld we_n", 32'(o_we), 32'd1);
          chk("ld oe_n", 32'(o_oe), 32'd0);
          chk("ld lb_n", 32'(o_lb), 32'd0);
          chk("ld ub_n", 32'(o_ub), 32'd0);
          chk("ld dq", 32'(o_dq), 32'(em[sel][hw[7:0]]));
        end
      end else begin
        chk_idle_pins("idle");
      end
      if (o_ack && ack_cycle < 0) begin
        ack_cycle = c;
        rd = o_rdata;
      end
      if (c == total - 1) chk("rdata", o_rdata, wr ? last_rd[sel] : exp_rd);
      @(posedge clk); #1;
    end
    if (wr) begin
      for (int h = 0; h < 2; h++)
        for (int b = 0; b < 2; b++)
          if (bm[2*h+b]) begin
            hw = {base, h[0]};
            em[sel][hw[7:0]][8*b +: 8] = wd[16*h + 8*b +: 8];
          end
    end else begin
      last_rd[sel] = exp_rd;
    end
  endtask

  int          ac, ac2;
  logic [31:0] rd;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] <= 16'h0; mem3[i] <= 16'h0;
      em[0][i] = 16'h0; em[1][i] = 16'h0;
    end
    // word at byte 0x104 occupies halfwords 0x82/0x83
    mem1[8'h82] <= 16'hBEEF; mem1[8'h83] <= 16'hDEAD;
    em[0][8'h82] = 16'hBEEF; em[0][8'h83] = 16'hDEAD;
    mem3[8'h82] <= 16'h3333; mem3[8'h83] <= 16'h4444;
    em[1][8'h82] = 16'h3333; em[1][8'h83] = 16'h4444;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;

    rst = 1'b1; t_sel = 1'b0; t_req = 1'b0; t_wren = 1'b0;
    t_addr = '0; t_wdata = '0; t_bmask = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_idle_pins("reset");
    chk("reset ack", 32'(o_ack), 32'd0);
    chk("reset stall", 32'(o_stall), 32'd0);
    chk("reset rdata", o_rdata, 32'h0);
    chk("reset addr", 32'(o_addr), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_access(1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 1'b0, ac, rd);
    chk("load ack cycle", 32'(ac), 32'd3);
    chk("load value", rd, 32'hDEADBEEF);

    run_access(1'b0, 1'b1, 32'h0000_0008, 32'h1234_5678, 4'hF, 1'b0, ac, rd);
    chk("full store ack cycle", 32'(ac), 32'd3);
    run_access(1'b0, 1'b0, 32'h0000_0008, 32'h0, 4'h0, 1'b0, ac, rd);
    chk("readback full store", rd, 32'h1234_5678);

    run_access(1'b0, 1'b1, 32'h0000_0008, 32'hAABB_CCDD, 4'b0100, 1'b0, ac, rd);
    chk("hi-only store ack cycle", 32'(ac), 32'd2);
    run_access(1'b0, 1'b0, 32'h0000_0008, 32'h0, 4'h0, 1'b0, ac, rd);
    chk("readback byte store", rd, 32'h12BB_5678);

    run_access(1'b0, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 1'b0, ac, rd);
    chk("empty store ack cycle", 32'(ac), 32'd1);
    run_access(1'b0, 1'b1, 32'h0000_0010, 32'h0000_CAFE, 4'b0011, 1'b0, ac, rd);
    chk("lo-only store ack cycle", 32'(ac), 32'd2);
    run_access(1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0, ac, rd);
    chk("readback lo store", rd, 32'h0000_CAFE);

    // Reset during the HI phase of a load
    t_sel = 1'b0; t_wren = 1'b0; t_addr = 32'h0000_0104; t_bmask = 4'h0; t_req = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("pre-reset in HI", 32'(o_addr), 32'h83);
    @(posedge clk); #1;
    rst = 1'b1; t_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_idle_pins("midrst");
    chk("midrst ack", 32'(o_ack), 32'd0);
    chk("midrst stall", 32'(o_stall), 32'd0);
    chk("midrst rdata", o_rdata, 32'h0);
    last_rd[0] = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    ac = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (o_ack) ac++;
      @(posedge clk); #1;
    end
    chk("no ack after reset", 32'(ac), 32'd0);

    // WAIT_CYC = 3: load then back-to-back store, then readback
    run_access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 1'b1, ac, rd);
    chk("w3 load ack cycle", 32'(ac), 32'd7);
    chk("w3 load value", rd, 32'h4444_3333);
    run_access(1'b1, 1'b1, 32'h0000_0104, 32'h55AA_33CC, 4'hF, 1'b0, ac2, rd);
    chk("w3 b2b ack cycle", 32'(ac + 1 + ac2), 32'd15);
    run_access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 1'b0, ac, rd);
    chk("w3 readback", rd, 32'h55AA_33CC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
